// File: rtl/rename_map_table.sv
// Speculative rename map for the 2-wide OoO core.
// Tracks the newest in-flight producer per logical register.
module rename_map_table #(
  parameter int ROB_W = 6,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_RNR,
  input  logic             recover,
  input  logic [4:0]       rs1l,
  input  logic [4:0]       rt1l,
  input  logic [4:0]       rs2l,
  input  logic [4:0]       rt2l,
  input  logic [4:0]       rd1l,
  input  logic [4:0]       rd2l,
  input  logic             rd1_en,
  input  logic             rd2_en,
  input  logic [ROB_W-1:0] rob_tag1,
  input  logic [ROB_W-1:0] rob_tag2,
  input  logic [4:0]       rd1l_c,
  input  logic [4:0]       rd2l_c,
  input  logic             rd1_en_c,
  input  logic             rd2_en_c,
  input  logic [ROB_W-1:0] rob_tag1_c,
  input  logic [ROB_W-1:0] rob_tag2_c,
  output logic [ROB_W-1:0] rs1_tag,
  output logic [ROB_W-1:0] rt1_tag,
  output logic [ROB_W-1:0] rs2_tag,
  output logic [ROB_W-1:0] rt2_tag,
  output logic             rs1_inrob,
  output logic             rt1_inrob,
  output logic             rs2_inrob,
  output logic             rt2_inrob,
  output logic             rr_valid,
  output logic             rd1_enc,
  output logic             rd2_enc
);

  logic [ROB_W-1:0] tag_q [NREG];
  logic [NREG-1:0]  vld_q;

  logic             rd1_act;
  logic             rd2_act;
  logic             wr1;
  logic             wr2;
  logic             c1_hit;
  logic             c2_hit;
  logic [ROB_W-1:0] rs1_nx;
  logic [ROB_W-1:0] rt1_nx;
  logic [ROB_W-1:0] rs2_nx;
  logic [ROB_W-1:0] rt2_nx;
  logic             rs1_in_nx;
  logic             rt1_in_nx;
  logic             rs2_in_nx;
  logic             rt2_in_nx;

  always_comb begin
    rd1_act = rd1_en && (rd1l != 5'd0);
    rd2_act = rd2_en && (rd2l != 5'd0);
    wr2     = rd2_act;
    // instruction 2 overwrites a shared destination
    wr1     = rd1_act && !(rd2_act && (rd2l == rd1l));
  end

  always_comb begin
    rs1_nx    = tag_q[rs1l];
    rs1_in_nx = (rs1l != 5'd0) && vld_q[rs1l];
    rt1_nx    = tag_q[rt1l];
    rt1_in_nx = (rt1l != 5'd0) && vld_q[rt1l];
    rs2_nx    = tag_q[rs2l];
    rs2_in_nx = (rs2l != 5'd0) && vld_q[rs2l];
    rt2_nx    = tag_q[rt2l];
    rt2_in_nx = (rt2l != 5'd0) && vld_q[rt2l];
    // instruction 2 sees instruction 1's result
    if (rd1_act && (rs2l == rd1l)) begin
      rs2_nx    = rob_tag1;
      rs2_in_nx = 1'b1;
    end
    if (rd1_act && (rt2l == rd1l)) begin
      rt2_nx    = rob_tag1;
      rt2_in_nx = 1'b1;
    end
  end

  always_comb begin
    c1_hit  = rd1_en_c && (rd1l_c != 5'd0) &&
              vld_q[rd1l_c] &&
              (tag_q[rd1l_c] == rob_tag1_c);
    c2_hit  = rd2_en_c && (rd2l_c != 5'd0) &&
              vld_q[rd2l_c] &&
              (tag_q[rd2l_c] == rob_tag2_c);
    rd2_enc = c2_hit;
    rd1_enc = c1_hit &&
              !(rd2_en_c && (rd2l_c == rd1l_c));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        tag_q[i] <= '0;
      end
      vld_q <= '0;
    end else if (recover) begin
      vld_q <= '0;
    end else begin
      if (rd1_enc) vld_q[rd1l_c] <= 1'b0;
      if (rd2_enc) vld_q[rd2l_c] <= 1'b0;
      // later writes win over the commit clears
      if (!stall_RNR) begin
        if (wr1) begin
          tag_q[rd1l] <= rob_tag1;
          vld_q[rd1l] <= 1'b1;
        end
        if (wr2) begin
          tag_q[rd2l] <= rob_tag2;
          vld_q[rd2l] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_tag   <= '0;
      rt1_tag   <= '0;
      rs2_tag   <= '0;
      rt2_tag   <= '0;
      rs1_inrob <= 1'b0;
      rt1_inrob <= 1'b0;
      rs2_inrob <= 1'b0;
      rt2_inrob <= 1'b0;
      rr_valid  <= 1'b0;
    end else if (recover) begin
      rs1_inrob <= 1'b0;
      rt1_inrob <= 1'b0;
      rs2_inrob <= 1'b0;
      rt2_inrob <= 1'b0;
      rr_valid  <= 1'b0;
    end else if (!stall_RNR) begin
      rs1_tag   <= rs1_nx;
      rt1_tag   <= rt1_nx;
      rs2_tag   <= rs2_nx;
      rt2_tag   <= rt2_nx;
      rs1_inrob <= rs1_in_nx;
      rt1_inrob <= rt1_in_nx;
      rs2_inrob <= rs2_in_nx;
      rt2_inrob <= rt2_in_nx;
      rr_valid  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rename_map_table.sv
// Bench for rename_map_table: directed scenarios plus
// randomized traffic against an array-based map model.
module tb_rename_map_table;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall_RNR, recover;
  logic [4:0] rs1l, rt1l, rs2l, rt2l, rd1l, rd2l;
  logic       rd1_en, rd2_en;
  logic [5:0] rob_tag1, rob_tag2;
  logic [4:0] rd1l_c, rd2l_c;
  logic       rd1_en_c, rd2_en_c;
  logic [5:0] rob_tag1_c, rob_tag2_c;
  logic [5:0] rs1_tag, rt1_tag, rs2_tag, rt2_tag;
  logic       rs1_inrob, rt1_inrob, rs2_inrob, rt2_inrob;
  logic       rr_valid, rd1_enc, rd2_enc;

  int compared   = 0;
  int mismatched = 0;

  logic [5:0] m_tag [32];
  logic       m_vld [32];
  logic [5:0] m_rt  [4];
  logic       m_ri  [4];
  logic       m_rrv;

  logic [28:0] dut_rr;
  assign dut_rr = {rs1_tag, rt1_tag, rs2_tag, rt2_tag,
                   rs1_inrob, rt1_inrob, rs2_inrob,
                   rt2_inrob, rr_valid};

  always #5 clk = ~clk;

  rename_map_table #(.ROB_W(6), .NREG(32)) dut (
    .clk(clk), .rst(rst), .stall_RNR(stall_RNR),
    .recover(recover),
    .rs1l(rs1l), .rt1l(rt1l), .rs2l(rs2l), .rt2l(rt2l),
    .rd1l(rd1l), .rd2l(rd2l),
    .rd1_en(rd1_en), .rd2_en(rd2_en),
    .rob_tag1(rob_tag1), .rob_tag2(rob_tag2),
    .rd1l_c(rd1l_c), .rd2l_c(rd2l_c),
    .rd1_en_c(rd1_en_c), .rd2_en_c(rd2_en_c),
    .rob_tag1_c(rob_tag1_c), .rob_tag2_c(rob_tag2_c),
    .rs1_tag(rs1_tag), .rt1_tag(rt1_tag),
    .rs2_tag(rs2_tag), .rt2_tag(rt2_tag),
    .rs1_inrob(rs1_inrob), .rt1_inrob(rt1_inrob),
    .rs2_inrob(rs2_inrob), .rt2_inrob(rt2_inrob),
    .rr_valid(rr_valid),
    .rd1_enc(rd1_enc), .rd2_enc(rd2_enc)
  );

  function automatic logic [28:0] exp_rr();
    return {m_rt[0], m_rt[1], m_rt[2], m_rt[3],
            m_ri[0], m_ri[1], m_ri[2], m_ri[3], m_rrv};
  endfunction

  // newest-mapping test straight from the commit rules
  function automatic logic m_enc2();
    return rd2_en_c && rd2l_c != 0 && m_vld[rd2l_c]
           && m_tag[rd2l_c] == rob_tag2_c;
  endfunction

  function automatic logic m_enc1();
    if (rd2_en_c && rd2l_c == rd1l_c) return 1'b0;
    return rd1_en_c && rd1l_c != 0 && m_vld[rd1l_c]
           && m_tag[rd1l_c] == rob_tag1_c;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_tag[r] = '0;
      m_vld[r] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      m_rt[i] = '0;
      m_ri[i] = 1'b0;
    end
    m_rrv = 1'b0;
  endtask

  task automatic idle();
    stall_RNR = 0; recover = 0;
    rs1l = 0; rt1l = 0; rs2l = 0; rt2l = 0;
    rd1l = 0; rd2l = 0; rd1_en = 0; rd2_en = 0;
    rob_tag1 = 0; rob_tag2 = 0;
    rd1l_c = 0; rd2l_c = 0; rd1_en_c = 0; rd2_en_c = 0;
    rob_tag1_c = 0; rob_tag2_c = 0;
  endtask

  // advance model by one clock, then the DUT; no checks here
  task automatic clk_step();
    logic       e1, e2;
    logic [4:0] s [4];
    e1 = m_enc1();
    e2 = m_enc2();
    s[0] = rs1l; s[1] = rt1l; s[2] = rs2l; s[3] = rt2l;
    if (recover) begin
      m_rrv = 1'b0;
      for (int i = 0; i < 4; i++) m_ri[i] = 1'b0;
      for (int r = 0; r < 32; r++) m_vld[r] = 1'b0;
    end else begin
      if (!stall_RNR) begin
        for (int i = 0; i < 4; i++) begin
          if (i >= 2 && rd1_en && rd1l != 0 && s[i] == rd1l) begin
            m_rt[i] = rob_tag1;
            m_ri[i] = 1'b1;
          end else begin
            m_rt[i] = m_tag[s[i]];
            m_ri[i] = s[i] != 0 && m_vld[s[i]];
          end
        end
        m_rrv = 1'b1;
      end
      if (e1) m_vld[rd1l_c] = 1'b0;
      if (e2) m_vld[rd2l_c] = 1'b0;
      if (!stall_RNR) begin
        if (rd1_en && rd1l != 0) begin
          m_tag[rd1l] = rob_tag1;
          m_vld[rd1l] = 1'b1;
        end
        if (rd2_en && rd2l != 0) begin
          m_tag[rd2l] = rob_tag2;
          m_vld[rd2l] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    idle();
    rd1l_c = 3; rd1_en_c = 1;
    rob_tag1_c = 6'($urandom);
    #2;
    compared++;
    if (dut_rr !== 29'd0) begin
      mismatched++;
      $display("FAIL reset_rr got %h want 0", dut_rr);
    end
    compared++;
    if (rd1_enc !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_enc got %b want 0", rd1_enc);
    end
    #1 rst = 0;
    rs1l = 3;
    clk_step();
    compared++;
    if (rs1_inrob !== 1'b0 || rr_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL first_lookup got inrob=%b vld=%b want 0 1",
               rs1_inrob, rr_valid);
    end
    compared++;
    if (rd1_enc !== 1'b0) begin
      mismatched++;
      $display("FAIL unmapped_enc got %b want 0", rd1_enc);
    end
  endtask

  task automatic test_rename_commit();
    idle();
    rd1l = 5; rob_tag1 = 12; rd1_en = 1;
    clk_step();
    idle();
    rs1l = 5;
    clk_step();
    compared++;
    if (rs1_tag !== 6'd12 || rs1_inrob !== 1'b1) begin
      mismatched++;
      $display("FAIL r5_lookup got %0d/%b want 12/1",
               rs1_tag, rs1_inrob);
    end
    rd1l_c = 5; rob_tag1_c = 12; rd1_en_c = 1;
    #1;
    compared++;
    if (rd1_enc !== 1'b1) begin
      mismatched++;
      $display("FAIL r5_commit got %b want 1", rd1_enc);
    end
    clk_step();
    idle();
    rs1l = 5;
    clk_step();
    compared++;
    if (rs1_inrob !== 1'b0) begin
      mismatched++;
      $display("FAIL r5_after_commit got %b want 0", rs1_inrob);
    end
  endtask

  task automatic test_same_pair();
    idle();
    rd1l = 7; rob_tag1 = 20; rd1_en = 1; rs2l = 7;
    clk_step();
    compared++;
    if (rs2_tag !== 6'd20 || rs2_inrob !== 1'b1) begin
      mismatched++;
      $display("FAIL bypass got %0d/%b want 20/1",
               rs2_tag, rs2_inrob);
    end
    idle();
    rd1l = 9; rd2l = 9; rd1_en = 1; rd2_en = 1;
    rob_tag1 = 21; rob_tag2 = 22;
    clk_step();
    idle();
    rs1l = 9;
    clk_step();
    compared++;
    if (rs1_tag !== 6'd22 || rs1_inrob !== 1'b1) begin
      mismatched++;
      $display("FAIL waw_pair got %0d/%b want 22/1",
               rs1_tag, rs1_inrob);
    end
    idle();
    rd1l_c = 9; rob_tag1_c = 21; rd1_en_c = 1;
    #1;
    compared++;
    if (rd1_enc !== 1'b0) begin
      mismatched++;
      $display("FAIL stale_commit got %b want 0", rd1_enc);
    end
    rd2l_c = 9; rob_tag2_c = 22; rd2_en_c = 1;
    #1;
    compared++;
    if (rd1_enc !== 1'b0 || rd2_enc !== 1'b1) begin
      mismatched++;
      $display("FAIL pair_commit got %b%b want 01",
               rd1_enc, rd2_enc);
    end
    clk_step();
  endtask

  task automatic test_newest();
    idle();
    rd1l = 4; rob_tag1 = 30; rd1_en = 1;
    clk_step();
    rob_tag1 = 31;
    clk_step();
    idle();
    rd1l_c = 4; rob_tag1_c = 30; rd1_en_c = 1;
    #1;
    compared++;
    if (rd1_enc !== 1'b0) begin
      mismatched++;
      $display("FAIL old_tag_enc got %b want 0", rd1_enc);
    end
    rs1l = 4;
    clk_step();
    compared++;
    if (rs1_tag !== 6'd31 || rs1_inrob !== 1'b1) begin
      mismatched++;
      $display("FAIL r4_kept got %0d/%b want 31/1",
               rs1_tag, rs1_inrob);
    end
    idle();
    rob_tag1_c = 31; rd1l_c = 4; rd1_en_c = 1;
    rd2l = 4; rob_tag2 = 33; rd2_en = 1;
    clk_step();
    idle();
    rd1l_c = 4; rob_tag1_c = 33; rd1_en_c = 1;
    #1;
    compared++;
    if (rd1_enc !== 1'b1) begin
      mismatched++;
      $display("FAIL rename_wins got %b want 1", rd1_enc);
    end
    rd1_en_c = 0;
    rs1l = 4;
    clk_step();
    compared++;
    if (rs1_tag !== 6'd33 || rs1_inrob !== 1'b1) begin
      mismatched++;
      $display("FAIL r4_new got %0d/%b want 33/1",
               rs1_tag, rs1_inrob);
    end
  endtask

  task automatic test_stall();
    idle();
    rd1l = 8; rob_tag1 = 40; rd1_en = 1;
    clk_step();
    idle();
    rs1l = 8;
    clk_step();
    idle();
    stall_RNR = 1;
    rd1l = 6; rob_tag1 = 41; rd1_en = 1;
    rs1l = 0; rt1l = 6;
    rd1l_c = 8; rob_tag1_c = 40; rd1_en_c = 1;
    clk_step();
    compared++;
    if (rs1_tag !== 6'd40 || rs1_inrob !== 1'b1
        || rr_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL stall_hold got %0d/%b/%b want 40/1/1",
               rs1_tag, rs1_inrob, rr_valid);
    end
    idle();
    rs1l = 6; rt1l = 8;
    clk_step();
    compared++;
    if (rs1_inrob !== 1'b0 || rt1_inrob !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_map got %b%b want 00",
               rs1_inrob, rt1_inrob);
    end
  endtask

  task automatic test_recover();
    idle();
    rd1l = 10; rob_tag1 = 44; rd1_en = 1;
    rd2l = 11; rob_tag2 = 45; rd2_en = 1;
    clk_step();
    idle();
    recover = 1; rs1l = 10;
    rd1l = 12; rob_tag1 = 46; rd1_en = 1;
    clk_step();
    compared++;
    if (rr_valid !== 1'b0 || rs1_inrob !== 1'b0) begin
      mismatched++;
      $display("FAIL recover_rr got %b/%b want 0/0",
               rr_valid, rs1_inrob);
    end
    idle();
    rs1l = 10; rt1l = 11; rs2l = 12;
    clk_step();
    compared++;
    if ({rs1_inrob, rt1_inrob, rs2_inrob} !== 3'b000
        || rr_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL recover_map got %b%b%b/%b want 000/1",
               rs1_inrob, rt1_inrob, rs2_inrob, rr_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      idle();
      recover   = ($urandom_range(0, 19) == 0);
      stall_RNR = ($urandom_range(0, 4) == 0);
      rs1l = 5'($urandom_range(0, 7));
      rt1l = 5'($urandom_range(0, 7));
      rs2l = 5'($urandom_range(0, 7));
      rt2l = 5'($urandom_range(0, 7));
      rd1l = 5'($urandom_range(0, 7));
      rd2l = 5'($urandom_range(0, 7));
      rd1_en = 1'($urandom);
      rd2_en = 1'($urandom);
      rob_tag1 = 6'($urandom);
      rob_tag2 = 6'($urandom);
      rd1l_c = 5'($urandom_range(0, 7));
      rd2l_c = 5'($urandom_range(0, 7));
      rd1_en_c = 1'($urandom);
      rd2_en_c = 1'($urandom);
      rob_tag1_c = $urandom_range(0, 1) ? m_tag[rd1l_c]
                                        : 6'($urandom);
      rob_tag2_c = $urandom_range(0, 1) ? m_tag[rd2l_c]
                                        : 6'($urandom);
      #1;
      compared++;
      if ({rd1_enc, rd2_enc} !== {m_enc1(), m_enc2()}) begin
        mismatched++;
        $display("FAIL rand_enc n=%0d got %b%b want %b%b", n,
                 rd1_enc, rd2_enc, m_enc1(), m_enc2());
      end
      clk_step();
      compared++;
      if (dut_rr !== exp_rr()) begin
        mismatched++;
        $display("FAIL rand_rr n=%0d got %h want %h", n,
                 dut_rr, exp_rr());
      end
    end
  endtask

  task automatic test_async_reset();
    idle();
    rs1l = 3;
    clk_step();
    compared++;
    if (rr_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL pre_rst got %b want 1", rr_valid);
    end
    #3 rst = 1;
    #1;
    compared++;
    if (dut_rr !== 29'd0) begin
      mismatched++;
      $display("FAIL async_rst got %h want 0", dut_rr);
    end
    #1 rst = 0;
    model_reset();
    rs1l = 5'($urandom_range(1, 7));
    clk_step();
    compared++;
    if (dut_rr !== exp_rr()) begin
      mismatched++;
      $display("FAIL post_rst got %h want %h", dut_rr, exp_rr());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rename_commit();
    test_same_pair();
    test_newest();
    test_stall();
    test_recover();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rename_map_table.md
Name: rename_map_table

Overview:
- Speculative rename map for the 2-wide out-of-order core.
- In RNR it records, for each logical register, the ROB tag of the newest in-flight producer, and hands source tags and in-ROB flags to the RR stage through an output register.
- At COM it decides whether each committing destination is still the newest mapping. Those results drive the ARF/ROB location table's commit enables (rd1_enc/rd2_enc).

Parameters:
- ROB_W, 6, ROB tag width (64-entry ROB).
- NREG, 32, number of logical registers (5-bit index).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- stall_RNR  in  1  freezes map writes and the RR output register
- recover  in  1  flush: invalidate all mappings and squash the RR output
- rs1l, rt1l, rs2l, rt2l  in  5 each  source logical registers, instructions 1/2
- rd1l, rd2l  in  5 each  destination logical registers
- rd1_en, rd2_en  in  1 each  destination write enables
- rob_tag1, rob_tag2  in  ROB_W each  ROB tags allocated to instructions 1/2 this cycle
- rd1l_c, rd2l_c  in  5 each  committing destinations
- rd1_en_c, rd2_en_c  in  1 each  committing instruction has a destination
- rob_tag1_c, rob_tag2_c  in  ROB_W each  ROB tags of the committing instructions
- rs1_tag, rt1_tag, rs2_tag, rt2_tag  out  ROB_W each  registered source tags for RR
- rs1_inrob, rt1_inrob, rs2_inrob, rt2_inrob  out  1 each  registered: 1 = value comes from the ROB (tag valid); 0 = value comes from the ARF
- rr_valid  out  1  registered: the RR output carries a renamed pair
- rd1_enc, rd2_enc  out  1 each  combinational: the committing destination is the newest mapping

Behaviour:
- Storage: tag[NREG] of ROB_W bits and vld[NREG] of 1 bit. Register 0 is never mapped: rd=0 is treated as rd_en=0, and the vld[0] read is forced to 0.
- Reset (async, rst high): all vld=0, all tag=0. All registered outputs = 0, including rr_valid. rd1_enc/rd2_enc follow their combinational equations.
- Lookup is combinational on the current map, with an intra-pair bypass. If rs2l or rt2l equals rd1l, rd1_en=1 and rd1l≠0, the source takes tag=rob_tag1 and inrob=1. Instruction 1 sources never bypass.
- RR output register, updated at posedge:
  - recover=1: rr_valid=0, inrob outputs=0, tag outputs hold.
  - else if stall_RNR=1: all RR outputs hold.
  - else: outputs load the bypassed lookup, and rr_valid=1.
- Rename write, applied when !recover && !stall_RNR:
  - rd1_en: tag[rd1l]=rob_tag1, vld=1.
  - rd2_en: tag[rd2l]=rob_tag2, vld=1.
  - If rd1l==rd2l and both are enabled, only instruction 2 is written.
- rd2_enc = rd2_en_c && rd2l_c≠0 && vld[rd2l_c] && tag[rd2l_c]==rob_tag2_c.
- rd1_enc = the same test for instruction 1, forced to 0 if rd2_en_c && rd2l_c==rd1l_c.
- Commit clear, applied when !recover:
  - If rdX_enc=1, vld[rdXl_c] is cleared, unless that register is renamed in the same cycle (rename wins).
  - Commit clears are independent of stall_RNR.
- Recover: at posedge all vld are cleared and tags are unchanged. Recover has priority over rename and commit in the same cycle.
- Reset asserted mid-operation clears the map immediately, with no clock required.

Test Plan:
- Reset then rename rs1l=3 (no writes) -> next cycle rs1_inrob=0, rr_valid=1; rd1_enc=0 for rd1l_c=3 with any tag.
- Cycle A: rd1l=5, rob_tag1=12, rd1_en=1. Cycle B: rs1l=5 -> rs1_tag=12, rs1_inrob=1. Then commit rd1l_c=5, rob_tag1_c=12 -> rd1_enc=1, and the following rename of rs1l=5 gives rs1_inrob=0.
- Same pair: rd1l=7, tag 20; rs2l=7 -> rs2_tag=20, rs2_inrob=1. rd1l=rd2l=9 with tags 21, 22 -> a later read of r9 gives 22. Committing tag 21 for r9 -> rd1_enc=0. Commit pair rd1l_c=rd2l_c=9 with tags 21, 22 -> rd1_enc=0, rd2_enc=1.
- Rename r4 to tag 30, then r4 to tag 31 -> commit r4 tag 30 gives enc=0 and r4 stays mapped to 31. Commit r4 tag 31 and rename r4 to tag 33 in the same cycle -> r4 is mapped to 33 with vld=1.
- stall_RNR=1 with rd1l=6, rd1_en=1 -> map unchanged and RR outputs held. A commit in the same cycle still clears its entry.
- Map several registers, then assert recover for 1 cycle -> rr_valid=0, and every later lookup returns inrob=0. Assert rst asynchronously mid-cycle -> outputs go to 0 immediately.
